// File: rtl/lane_memory.sv
// Byte-laned memory with rotated, possibly row-crossing accesses and a one-deep
// response stage; illegal requests are faulted, counted and leave RAM untouched.
module lane_memory #(
  parameter int SIZE_LOG2     = 13,
  parameter int LANES         = 4,
  parameter int MISALIGN_TRAP = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [SIZE_LOG2-1:0]   req_addr,
  input  logic [8*LANES-1:0]     req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [8*LANES-1:0]     resp_rdata,
  output logic                   resp_fault,
  output logic [7:0]             fault_count
);
  localparam int OFF_W = $clog2(LANES);
  localparam int ROW_W = SIZE_LOG2 - OFF_W;
  localparam int DEPTH = 2 ** ROW_W;

  typedef enum logic {IDLE, RESP} stateT;

  stateT              state;
  logic               accept;
  logic               reqFault;
  logic [OFF_W-1:0]   reqOffset;
  logic [ROW_W-1:0]   reqRow;
  logic [3:0]         reqBytes;
  logic [LANES-1:0]   laneEn;
  logic [OFF_W-1:0]   laneK     [LANES];
  logic [ROW_W-1:0]   laneRow   [LANES];
  logic [7:0]         laneWdata [LANES];
  logic [7:0]         rdLane    [LANES];

  logic               respFaultQ;
  logic               respLoad;
  logic [OFF_W-1:0]   respOffset;
  logic [1:0]         respSize;
  logic               respSigned;
  logic [7:0]         faultCountQ;

  logic [3:0]         respBytes;
  logic [OFF_W-1:0]   srcLane;
  logic               signBit;
  logic [8*LANES-1:0] rotated;

  assign reqOffset = req_addr[OFF_W-1:0];
  assign reqRow    = req_addr[SIZE_LOG2-1:OFF_W];
  assign reqBytes  = 4'd1 << req_size;
  assign req_ready = !rst && (state == IDLE || resp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    reqFault = (req_size == 2'b11) && (LANES == 4);
    if (MISALIGN_TRAP != 0 && (reqOffset & OFF_W'(reqBytes - 4'd1)) != '0)
      reqFault = 1'b1;
  end

  // Lanes below the start offset belong to the next row, which wraps at the top.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      laneK[j]     = OFF_W'(j) - reqOffset;
      laneEn[j]    = 4'(laneK[j]) < reqBytes;
      laneWdata[j] = req_wdata[8*laneK[j] +: 8];
      laneRow[j]   = (OFF_W'(j) < reqOffset) ? reqRow + ROW_W'(1) : reqRow;
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : gLane
    logic [7:0] mem [DEPTH];
    logic [7:0] rdByte;

    // Read register only moves on accept so a stalled response stays stable.
    always_ff @(posedge clk) begin
      if (accept) begin
        if (req_we && !reqFault && laneEn[j])
          mem[laneRow[j]] <= laneWdata[j];
        rdByte <= mem[laneRow[j]];
      end
    end

    assign rdLane[j] = rdByte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      respFaultQ  <= 1'b0;
      respLoad    <= 1'b0;
      respOffset  <= '0;
      respSize    <= '0;
      respSigned  <= 1'b0;
      faultCountQ <= '0;
    end else begin
      case (state)
        IDLE:    if (accept) state <= RESP;
        RESP:    if (resp_ready && !accept) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (accept) begin
        respFaultQ <= reqFault;
        respLoad   <= !req_we && !reqFault;
        respOffset <= reqOffset;
        respSize   <= req_size;
        respSigned <= req_signed;
        if (reqFault && faultCountQ != 8'hFF)
          faultCountQ <= faultCountQ + 8'd1;
      end
    end
  end

  // Undo the lane rotation, then zero- or sign-extend above the access size.
  always_comb begin
    respBytes = 4'd1 << respSize;
    rotated   = '0;
    signBit   = 1'b0;
    srcLane   = '0;
    for (int k = 0; k < LANES; k++) begin
      srcLane = OFF_W'(k) + respOffset;
      if (4'(k) < respBytes) begin
        rotated[8*k +: 8] = rdLane[srcLane];
        if (4'(k) == respBytes - 4'd1)
          signBit = rdLane[srcLane][7];
      end
    end
    for (int k = 0; k < LANES; k++) begin
      if (4'(k) >= respBytes && respSigned && signBit)
        rotated[8*k +: 8] = 8'hFF;
    end
    resp_rdata = respLoad ? rotated : '0;
  end

  assign resp_valid  = (state == RESP);
  assign resp_fault  = respFaultQ;
  assign fault_count = faultCountQ;

endmodule

// File: tb/tb_lane_memory.sv
// Directed bench for lane_memory: one instance splits misaligned accesses,
// a second instance traps them; both share the request bus but not req_valid.
module tb_lane_memory;
  logic        clk = 1'b0;
  logic        rst;
  logic        reqValidMain, reqValidTrap;
  logic        reqWe, reqSigned, respReady;
  logic [1:0]  reqSize;
  logic [12:0] reqAddr;
  logic [31:0] reqWdata;

  logic        readyMain, validMain, faultMain;
  logic [31:0] rdataMain;
  logic [7:0]  countMain;
  logic        readyTrap, validTrap, faultTrap;
  logic [31:0] rdataTrap;
  logic [7:0]  countTrap;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] rdata;
  logic        fault;

  always #5 clk = ~clk;

  lane_memory #(.SIZE_LOG2(13), .LANES(4), .MISALIGN_TRAP(0)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValidMain), .req_ready(readyMain),
    .req_we(reqWe), .req_size(reqSize), .req_signed(reqSigned), .req_addr(reqAddr),
    .req_wdata(reqWdata), .resp_valid(validMain), .resp_ready(respReady),
    .resp_rdata(rdataMain), .resp_fault(faultMain), .fault_count(countMain)
  );

  lane_memory #(.SIZE_LOG2(13), .LANES(4), .MISALIGN_TRAP(1)) dutTrap (
    .clk(clk), .rst(rst), .req_valid(reqValidTrap), .req_ready(readyTrap),
    .req_we(reqWe), .req_size(reqSize), .req_signed(reqSigned), .req_addr(reqAddr),
    .req_wdata(reqWdata), .resp_valid(validTrap), .resp_ready(respReady),
    .resp_rdata(rdataTrap), .resp_fault(faultTrap), .fault_count(countTrap)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic setRequest(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [12:0] addr, input logic [31:0] wdata);
    reqWe     = we;
    reqSize   = size;
    reqSigned = sgn;
    reqAddr   = addr;
    reqWdata  = wdata;
  endtask

  // One complete transaction with resp_ready held high; returns the response.
  task automatic applyStimulus(input bit useTrap, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [12:0] addr,
                               input logic [31:0] wdata,
                               output logic [31:0] rdataOut, output logic faultOut);
    int n;
    @(negedge clk);
    setRequest(we, size, sgn, addr, wdata);
    if (useTrap) reqValidTrap = 1'b1;
    else         reqValidMain = 1'b1;
    n = 0;
    while (!(useTrap ? readyTrap : readyMain) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reqAccepted", useTrap ? readyTrap : readyMain, 1);
    @(posedge clk);
    #1;
    reqValidMain = 1'b0;
    reqValidTrap = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(useTrap ? validTrap : validMain) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("respArrived", useTrap ? validTrap : validMain, 1);
    rdataOut = useTrap ? rdataTrap : rdataMain;
    faultOut = useTrap ? faultTrap : faultMain;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    reqValidMain = 1'b0;
    reqValidTrap = 1'b0;
    respReady = 1'b1;
    setRequest(1'b0, 2'b00, 1'b0, 13'h0, 32'h0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReqReady", readyMain, 0);
    checkOutput("rstRespValid", validMain, 0);
    checkOutput("rstRdata", rdataMain, 0);
    checkOutput("rstFault", faultMain, 0);
    checkOutput("rstFaultCount", countMain, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleReqReady", readyMain, 1);

    // Unaligned word store crossing into the next row
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 13'h0003, 32'hDDCCBBAA, rdata, fault);
    checkOutput("storeRdata", rdata, 0);
    checkOutput("storeFault", fault, 0);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 13'h0003, 32'h0, rdata, fault);
    checkOutput("byte3", rdata, 32'h000000AA);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 13'h0004, 32'h0, rdata, fault);
    checkOutput("byte4", rdata, 32'h000000BB);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 13'h0005, 32'h0, rdata, fault);
    checkOutput("byte5", rdata, 32'h000000CC);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 13'h0006, 32'h0, rdata, fault);
    checkOutput("byte6", rdata, 32'h000000DD);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 13'h0003, 32'h0, rdata, fault);
    checkOutput("word3", rdata, 32'hDDCCBBAA);

    // Top-row wrap into row 0
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 13'h1FFE, 32'h11223344, rdata, fault);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 13'h1FFE, 32'h0, rdata, fault);
    checkOutput("wrapWord", rdata, 32'h11223344);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 13'h0000, 32'h0, rdata, fault);
    checkOutput("wrapByte0", rdata, 32'h00000022);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 13'h0001, 32'h0, rdata, fault);
    checkOutput("wrapByte1", rdata, 32'h00000011);

    // Sign and zero extension
    applyStimulus(0, 1'b1, 2'b00, 1'b0, 13'h0011, 32'h00000000, rdata, fault);
    applyStimulus(0, 1'b1, 2'b00, 1'b0, 13'h0010, 32'h00000080, rdata, fault);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 13'h0010, 32'h0, rdata, fault);
    checkOutput("signedByte", rdata, 32'hFFFFFF80);
    applyStimulus(0, 1'b0, 2'b01, 1'b0, 13'h0010, 32'h0, rdata, fault);
    checkOutput("unsignedHalf", rdata, 32'h00000080);
    applyStimulus(0, 1'b0, 2'b01, 1'b1, 13'h0010, 32'h0, rdata, fault);
    checkOutput("signedHalfPos", rdata, 32'h00000080);
    applyStimulus(0, 1'b1, 2'b01, 1'b0, 13'h0021, 32'h00008001, rdata, fault);
    applyStimulus(0, 1'b0, 2'b01, 1'b1, 13'h0021, 32'h0, rdata, fault);
    checkOutput("signedHalfNeg", rdata, 32'hFFFF8001);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 13'h0022, 32'h0, rdata, fault);
    checkOutput("unsignedByteHi", rdata, 32'h00000080);

    // Double access is illegal with four lanes
    applyStimulus(0, 1'b1, 2'b11, 1'b0, 13'h0010, 32'hFFFFFFFF, rdata, fault);
    checkOutput("dblStoreFault", fault, 1);
    checkOutput("dblStoreRdata", rdata, 0);
    checkOutput("dblCount1", countMain, 1);
    applyStimulus(0, 1'b0, 2'b11, 1'b0, 13'h0010, 32'h0, rdata, fault);
    checkOutput("dblLoadFault", fault, 1);
    checkOutput("dblLoadRdata", rdata, 0);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 13'h0010, 32'h0, rdata, fault);
    checkOutput("dblNoWrite", rdata, 32'hFFFFFF80);
    checkOutput("loadNoFault", fault, 0);
    checkOutput("dblCount2", countMain, 2);

    // Stream faulted requests one per cycle up to and past saturation
    @(negedge clk);
    setRequest(1'b0, 2'b11, 1'b0, 13'h0000, 32'h0);
    reqValidMain = 1'b1;
    repeat (253) @(posedge clk);
    #1;
    reqValidMain = 1'b0;
    @(negedge clk);
    checkOutput("countAt255", countMain, 255);
    applyStimulus(0, 1'b0, 2'b11, 1'b0, 13'h0000, 32'h0, rdata, fault);
    checkOutput("satFault", fault, 1);
    @(negedge clk);
    checkOutput("countSaturated", countMain, 255);

    // Misalignment trap instance
    applyStimulus(1, 1'b1, 2'b01, 1'b0, 13'h0000, 32'h00005678, rdata, fault);
    checkOutput("trapAlignedOk", fault, 0);
    applyStimulus(1, 1'b1, 2'b01, 1'b0, 13'h0001, 32'h00001234, rdata, fault);
    checkOutput("trapHalfFault", fault, 1);
    checkOutput("trapHalfRdata", rdata, 0);
    checkOutput("trapCount1", countTrap, 1);
    applyStimulus(1, 1'b0, 2'b01, 1'b0, 13'h0000, 32'h0, rdata, fault);
    checkOutput("trapUnchanged", rdata, 32'h00005678);
    applyStimulus(1, 1'b0, 2'b00, 1'b0, 13'h0001, 32'h0, rdata, fault);
    checkOutput("trapByteOk", rdata, 32'h00000056);
    checkOutput("trapByteNoFault", fault, 0);
    applyStimulus(1, 1'b0, 2'b10, 1'b0, 13'h0002, 32'h0, rdata, fault);
    checkOutput("trapWordFault", fault, 1);
    checkOutput("trapWordRdata", rdata, 0);
    checkOutput("trapCount2", countTrap, 2);

    // Back-to-back store then loads of the same bytes
    @(negedge clk);
    setRequest(1'b1, 2'b10, 1'b0, 13'h0040, 32'hCAFEF00D);
    reqValidMain = 1'b1;
    @(posedge clk);
    #1;
    setRequest(1'b0, 2'b10, 1'b0, 13'h0040, 32'h0);
    @(negedge clk);
    checkOutput("b2bStoreValid", validMain, 1);
    checkOutput("b2bStoreRdata", rdataMain, 0);
    @(posedge clk);
    #1;
    setRequest(1'b0, 2'b00, 1'b0, 13'h0043, 32'h0);
    @(negedge clk);
    checkOutput("b2bWord", rdataMain, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    setRequest(1'b0, 2'b01, 1'b1, 13'h0042, 32'h0);
    @(negedge clk);
    checkOutput("b2bByte", rdataMain, 32'h000000CA);
    @(posedge clk);
    #1;
    reqValidMain = 1'b0;
    @(negedge clk);
    checkOutput("b2bHalf", rdataMain, 32'hFFFFCAFE);
    @(negedge clk);
    checkOutput("b2bDrained", validMain, 0);

    // Backpressure holds the response and blocks new requests
    @(negedge clk);
    respReady = 1'b0;
    setRequest(1'b0, 2'b00, 1'b1, 13'h0010, 32'h0);
    reqValidMain = 1'b1;
    @(posedge clk);
    #1;
    setRequest(1'b0, 2'b01, 1'b0, 13'h0010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bpValid", validMain, 1);
      checkOutput("bpRdata", rdataMain, 32'hFFFFFF80);
      checkOutput("bpReqReady", readyMain, 0);
    end
    respReady = 1'b1;
    @(posedge clk);
    #1;
    setRequest(1'b0, 2'b00, 1'b0, 13'h0003, 32'h0);
    @(negedge clk);
    checkOutput("bpHalfAfter", rdataMain, 32'h00000080);
    @(posedge clk);
    #1;
    reqValidMain = 1'b0;
    @(negedge clk);
    checkOutput("bpByteAfter", rdataMain, 32'h000000AA);

    // Reset while a response is pending
    @(negedge clk);
    respReady = 1'b0;
    setRequest(1'b0, 2'b10, 1'b0, 13'h1FFE, 32'h0);
    reqValidMain = 1'b1;
    @(posedge clk);
    #1;
    reqValidMain = 1'b0;
    @(negedge clk);
    checkOutput("preRstValid", validMain, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstValid", validMain, 0);
    checkOutput("midRstCount", countMain, 0);
    checkOutput("midRstReady", readyMain, 0);
    checkOutput("midRstRdata", rdataMain, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstValid", validMain, 0);
    respReady = 1'b1;
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 13'h1FFE, 32'h0, rdata, fault);
    checkOutput("postRstWord", rdata, 32'h11223344);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 13'h0003, 32'h0, rdata, fault);
    checkOutput("postRstByte", rdata, 32'h000000AA);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
